alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a registered 4-bit ALU interface, with a handshaked response register.
// Optional macro ALU_SEQ_ERR_CHECK_EN flags opcodes 101..111 as illegal in the response.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic [2:0] rsp_op,
    output logic       rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          push;
    logic          pop;
    logic [10:0]   head;

    assign empty     = (count == '0);
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_op     <= '0;
`ifdef ALU_SEQ_ERR_CHECK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {alu_op, alu_b, alu_a} <= head;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_op    <= alu_op;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`ifdef ALU_SEQ_ERR_CHECK_EN
                    if (alu_op > 3'd4) begin
                        rsp_result <= '0;
                        rsp_carry  <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_carry  <= alu_carry;
                        rsp_err    <= 1'b0;
                    end
`else
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
`endif
                end
                RESP: begin
                    // Release the response and issue the next command in the same edge.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            {alu_op, alu_b, alu_a} <= head;
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ALU_SEQ_ERR_CHECK_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
// Expectations follow ALU_SEQ_ERR_CHECK_EN when it is defined.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic [2:0] rsp_op;
    logic       rsp_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] result;
        logic       carry;
        logic       err;
        int         cyc;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t obs_q[$];

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Downstream ALU; illegal opcodes return all ones so masking is visible.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return 5'h1F;
        endcase
    endfunction

    always_comb {alu_carry, alu_result} = alu_model(alu_a, alu_b, alu_op);

    function automatic rsp_t expect_of(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        rsp_t r;
        r.op = op;
        {r.carry, r.result} = alu_model(a, b, op);
        r.err = 1'b0;
`ifdef ALU_SEQ_ERR_CHECK_EN
        if (op > 3'd4) begin
            r.result = 4'd0;
            r.carry  = 1'b0;
            r.err    = 1'b1;
        end
`endif
        r.cyc = 0;
        return r;
    endfunction

    task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input int tries, output bit accepted);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < tries && !accepted; i++) begin
            if (cmd_ready === 1'b1) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (accepted) exp_q.push_back(expect_of(a, b, op));
    endtask

    // Records handshaked responses only; callers hold rsp_ready high.
    task automatic collect(input int n, input int budget);
        rsp_t r;
        obs_q.delete();
        for (int i = 0; i < budget && obs_q.size() < n; i++) begin
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                r.op = rsp_op;
                r.result = rsp_result;
                r.carry = rsp_carry;
                r.err = rsp_err;
                r.cyc = cyc;
                obs_q.push_back(r);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== 11'd0) begin
            n_err++;
            $display("[TB] FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_op});
        end
        n_cmp++;
        if ({rsp_result, rsp_carry, rsp_op, rsp_err} !== 9'd0) begin
            n_err++;
            $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_result, rsp_carry, rsp_op, rsp_err});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        bit acc;
        rsp_t e;
        offer(4'd9, 4'd8, 3'b000, 4, acc);
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("[TB] FAIL add_accept: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({alu_a, alu_b, alu_op, rsp_valid} !== {4'd9, 4'd8, 3'b000, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL add_issue: got %h expected %h", {alu_a, alu_b, alu_op, rsp_valid}, {4'd9, 4'd8, 3'b000, 1'b0});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_op, rsp_err} !== {1'b1, 4'b0001, 1'b1, 3'b000, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL add_latency: got %h expected %h", {rsp_valid, rsp_result, rsp_carry, rsp_op, rsp_err}, {1'b1, 4'b0001, 1'b1, 3'b000, 1'b0});
        end
        rsp_ready = 1'b1;
        collect(1, 6);
        rsp_ready = 1'b0;
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_err++;
            $display("[TB] FAIL add_rsp_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err} !== {e.op, e.result, e.carry, e.err}) begin
                n_err++;
                $display("[TB] FAIL add_scoreboard: got %h expected %h", {obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err}, {e.op, e.result, e.carry, e.err});
            end
        end
        n_cmp++;
        if ({rsp_valid, alu_a, alu_b} !== {1'b0, 4'd9, 4'd8}) begin
            n_err++;
            $display("[TB] FAIL add_idle_hold: got %h expected %h", {rsp_valid, alu_a, alu_b}, {1'b0, 4'd9, 4'd8});
        end
    endtask

    task automatic test_sub();
        bit acc;
        rsp_t e;
        offer(4'd3, 4'd5, 3'b001, 4, acc);
        rsp_ready = 1'b1;
        collect(1, 10);
        rsp_ready = 1'b0;
        n_cmp++;
        if (!acc || obs_q.size() != 1) begin
            n_err++;
            $display("[TB] FAIL sub_rsp_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err} !== {3'b001, 4'b1110, 1'b1, 1'b0}
                || e.result !== 4'b1110) begin
                n_err++;
                $display("[TB] FAIL sub_result: got %h expected %h", {obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err}, {3'b001, 4'b1110, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int n_acc = 0;
        rsp_t e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(4'(i * 3 + 1), 4'(i + 2), 3'(i % 5), 3, acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc != DEPTH + 1 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_accepted: got %0d ready=%b expected %0d ready=0", n_acc, cmd_ready, DEPTH + 1);
        end
        rsp_ready = 1'b1;
        collect(DEPTH + 1, 40);
        rsp_ready = 1'b0;
        n_cmp++;
        if (obs_q.size() != DEPTH + 1) begin
            n_err++;
            $display("[TB] FAIL bp_rsp_count: got %0d expected %0d", obs_q.size(), DEPTH + 1);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({obs_q[i].op, obs_q[i].result, obs_q[i].carry, obs_q[i].err} !== {e.op, e.result, e.carry, e.err}) begin
                n_err++;
                $display("[TB] FAIL bp_order_%0d: got %h expected %h", i, {obs_q[i].op, obs_q[i].result, obs_q[i].carry, obs_q[i].err}, {e.op, e.result, e.carry, e.err});
            end
        end
    endtask

    task automatic test_logic_stream();
        bit acc;
        rsp_t e;
        logic [3:0] want [3] = '{4'h8, 4'hE, 4'h6};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) offer(4'hC, 4'hA, 3'(i + 2), 4, acc);
        collect(3, 20);
        rsp_ready = 1'b0;
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_err++;
            $display("[TB] FAIL stream_rsp_count: got %0d expected 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q[i].result !== want[i] || {obs_q[i].op, obs_q[i].carry, obs_q[i].err} !== {e.op, e.carry, e.err}) begin
                n_err++;
                $display("[TB] FAIL stream_result_%0d: got %h expected %h", i, obs_q[i].result, want[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (obs_q[i].cyc - obs_q[i-1].cyc != 2) begin
                    n_err++;
                    $display("[TB] FAIL stream_spacing_%0d: got %0d expected 2", i, obs_q[i].cyc - obs_q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_illegal_op();
        bit acc;
        rsp_t e;
        offer(4'd7, 4'd3, 3'b110, 4, acc);
        rsp_ready = 1'b1;
        collect(1, 10);
        rsp_ready = 1'b0;
        n_cmp++;
        if (!acc || obs_q.size() != 1) begin
            n_err++;
            $display("[TB] FAIL illegal_rsp_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err} !== {e.op, e.result, e.carry, e.err}) begin
                n_err++;
                $display("[TB] FAIL illegal_rsp: got %h expected %h", {obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err}, {e.op, e.result, e.carry, e.err});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit seen = 1'b0;
        rsp_t e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) offer(4'(i + 5), 4'd1, 3'd0, 4, acc);
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rstmid_reach_resp: got %b expected 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_op, rsp_result, rsp_carry, rsp_op, rsp_err} !== {1'b1, 21'd0}) begin
            n_err++;
            $display("[TB] FAIL rstmid_outputs: got %h expected %h", {cmd_ready, rsp_valid, alu_a, alu_b, alu_op, rsp_result, rsp_carry, rsp_op, rsp_err}, {1'b1, 21'd0});
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0 || alu_a !== 4'd0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("[TB] FAIL rstmid_no_response: got 1 expected 0");
        end
        offer(4'd2, 4'd2, 3'd0, 4, acc);
        rsp_ready = 1'b1;
        collect(1, 10);
        rsp_ready = 1'b0;
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_err++;
            $display("[TB] FAIL rstmid_restart_count: got %0d expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err} !== {3'd0, 4'd4, 1'b0, 1'b0}
                || e.result !== 4'd4) begin
                n_err++;
                $display("[TB] FAIL rstmid_restart: got %h expected %h", {obs_q[0].op, obs_q[0].result, obs_q[0].carry, obs_q[0].err}, {3'd0, 4'd4, 1'b0, 1'b0});
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_logic_stream();
        test_illegal_op();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
